// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//   Shared constants and shadow-stage field layout for hazard_fwd_unit.
//
//   Operand-select encoding driven on fwd_a / fwd_b:
//     FWD_RF  (00) register-file value
//     FWD_WB  (01) WB-stage result
//     FWD_MEM (10) MEM-stage ALU result
//
//   Shadow-stage record layout (MSB first):
//     EX  : {rs, rt, rd_attr_t, dst, wr_attr_t}
//     MEM : {dst, wr_attr_t}
//     WB  : {dst, rw}
//   Each stage additionally carries its own vld bit in hazard_stage_reg.
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Write-side attributes of an in-flight instruction.
  typedef struct packed {
    logic rw;
    logic ld;
  } wr_attr_t;

  // Read-side attributes, only needed while the instruction sits in EX.
  typedef struct packed {
    logic uses_rs;
    logic uses_rt;
  } rd_attr_t;

  localparam int WR_ATTR_W = $bits(wr_attr_t);
  localparam int RD_ATTR_W = $bits(rd_attr_t);

endpackage

// File: rtl/hazard_stage_reg.sv
// -----------------------------------------------------------------------------
// hazard_stage_reg
//   One shadow pipeline stage: a valid bit plus a W-bit payload.
//   The payload is only overwritten when a valid entry is accepted, so a
//   squashed or empty slot just drops its vld bit.
//
//   Ports:
//     clk      in   1   pipeline clock, rising edge
//     rst      in   1   synchronous, active-high reset (clears vld and payload)
//     vld_in   in   1   incoming entry is real
//     squash   in   1   discard the incoming entry (vld_q <= 0)
//     data_in  in   W   incoming payload
//     vld_q    out  1   stage holds a real entry
//     data_q   out  W   registered payload
// -----------------------------------------------------------------------------
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_in,
  input  logic         squash,
  input  logic [W-1:0] data_in,
  output logic         vld_q,
  output logic [W-1:0] data_q
);

  logic accept;
  assign accept = vld_in & ~squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        data_q <= data_in;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//   Hazard detection and operand forwarding for a 5-stage MIPS pipeline.
//   Tracks its own shadow of the EX/MEM/WB destinations, captured from the
//   ID-stage decode, and produces:
//     - fwd_a / fwd_b : 2-bit selects for the EX-stage 3:1 operand muxes
//     - stall_if_id   : hold PC and IF/ID
//     - bubble_ex     : load a NOP into ID/EX
//
//   Optional feature macro: HAZ_MULDIV_EN
//     Defined   : adds parameter MULDIV_CYCLES, port id_muldiv and a busy
//                 counter that stalls the front end while a mult/div occupies EX.
//     Undefined : stalls come from load-use hazards only.
//
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     id_valid                    ID holds a real instruction
//     id_rs, id_rt                ID source registers
//     id_uses_rs, id_uses_rt      ID instruction reads rs / rt
//     id_dst                      resolved destination register
//     id_regwrite, id_load        ID writes the RF / is a load
//     id_muldiv                   mult/div start (HAZ_MULDIV_EN only)
//     flush                       taken branch/jump in EX: squash ID and EX
//     stall_if_id, bubble_ex      stall controls
//     fwd_a, fwd_b                operand selects (00 RF, 01 WB, 10 MEM)
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
`ifdef HAZ_MULDIV_EN
  , parameter int MULDIV_CYCLES = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_load,
`ifdef HAZ_MULDIV_EN
  input  logic              id_muldiv,
`endif
  input  logic              flush,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam int EX_W  = 3 * REG_AW + RD_ATTR_W + WR_ATTR_W;
  localparam int MEM_W = REG_AW + WR_ATTR_W;
  localparam int WB_W  = REG_AW + 1;

  // Priority select for one EX operand: MEM beats WB, $0 never forwards
  // (the dst!=0 term is folded into mem_ok / wb_ok).
  function automatic logic [1:0] fwd_sel(
    input logic              uses,
    input logic [REG_AW-1:0] src,
    input logic              mem_ok,
    input logic [REG_AW-1:0] mem_dst,
    input logic              wb_ok,
    input logic [REG_AW-1:0] wb_dst
  );
    if (uses && mem_ok && (mem_dst == src)) begin
      return FWD_MEM;
    end else if (uses && wb_ok && (wb_dst == src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  wr_attr_t          id_wr;
  rd_attr_t          id_rd;
  logic [EX_W-1:0]   ex_d_p0;
  logic [EX_W-1:0]   ex_q_p0;
  logic              vld_p0;
  logic [MEM_W-1:0]  mem_q_p1;
  logic              vld_p1;
  logic [WB_W-1:0]   wb_q_p2;
  logic              vld_p2;

  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  rd_attr_t          ex_rd;
  logic [REG_AW-1:0] ex_dst;
  wr_attr_t          ex_wr;
  logic [REG_AW-1:0] mem_dst;
  wr_attr_t          mem_wr;
  logic [REG_AW-1:0] wb_dst;
  logic              wb_rw;

  logic              ld_hz;
  logic              muldiv_busy;
  logic              mem_ok;
  logic              wb_ok;

  assign id_wr   = {id_regwrite, id_load};
  assign id_rd   = {id_uses_rs, id_uses_rt};
  assign ex_d_p0 = {id_rs, id_rt, id_rd, id_dst, id_wr};

  // ---- ID -> EX shadow: capture only when not stalled and not flushed ----
  hazard_stage_reg #(.W(EX_W)) u_ex_stage (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (id_valid),
    .squash  (stall_if_id | flush),
    .data_in (ex_d_p0),
    .vld_q   (vld_p0),
    .data_q  (ex_q_p0)
  );

  assign {ex_rs, ex_rt, ex_rd, ex_dst, ex_wr} = ex_q_p0;

  // ---- EX -> MEM shadow ----
  hazard_stage_reg #(.W(MEM_W)) u_mem_stage (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_p0),
    .squash  (1'b0),
    .data_in ({ex_dst, ex_wr}),
    .vld_q   (vld_p1),
    .data_q  (mem_q_p1)
  );

  assign {mem_dst, mem_wr} = mem_q_p1;

  // ---- MEM -> WB shadow ----
  hazard_stage_reg #(.W(WB_W)) u_wb_stage (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_p1),
    .squash  (1'b0),
    .data_in ({mem_dst, mem_wr.rw}),
    .vld_q   (vld_p2),
    .data_q  (wb_q_p2)
  );

  assign {wb_dst, wb_rw} = wb_q_p2;

  // A load in EX whose result a source of the ID instruction needs.
  assign ld_hz = id_valid & vld_p0 & ex_wr.ld & ex_wr.rw & (ex_dst != '0)
               & ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));

`ifdef HAZ_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_CYCLES);

  logic [CNT_W-1:0] busy_cnt;
  logic             muldiv_start;

  assign muldiv_start = id_valid & id_muldiv & ~stall_if_id & ~flush;
  assign muldiv_busy  = (busy_cnt != '0);

  // Loaded when the mult/div enters EX; a flush does not cancel it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (muldiv_start) begin
      busy_cnt <= CNT_W'(MULDIV_CYCLES - 1);
    end else if (muldiv_busy) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end
`else
  assign muldiv_busy = 1'b0;
`endif

  // Flush wins over a stall: the PC must be redirected, ID/EX still gets a NOP.
  assign stall_if_id = ~rst & ~flush & (ld_hz | muldiv_busy);
  assign bubble_ex   = ~rst & (ld_hz | muldiv_busy | flush);

  assign mem_ok = vld_p1 & mem_wr.rw & ~mem_wr.ld & (mem_dst != '0);
  assign wb_ok  = vld_p2 & wb_rw & (wb_dst != '0);

  assign fwd_a = (rst | ~vld_p0) ? FWD_RF
               : fwd_sel(ex_rd.uses_rs, ex_rs, mem_ok, mem_dst, wb_ok, wb_dst);
  assign fwd_b = (rst | ~vld_p0) ? FWD_RF
               : fwd_sel(ex_rd.uses_rt, ex_rt, mem_ok, mem_dst, wb_ok, wb_dst);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
//   Directed bench for hazard_fwd_unit. A history-based model records which
//   instruction entered EX on each cycle; the EX/MEM/WB occupants are then
//   simply the entries of the current, previous and second-previous cycle.
//   Build with +define+HAZ_MULDIV_EN to exercise the mult/div stall.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

`ifdef HAZ_MULDIV_EN
  localparam int MC = 4;
`else
  localparam int MC = 0;
`endif

  typedef struct packed {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit [4:0] dst;
    bit       urs;
    bit       urt;
    bit       rw;
    bit       ld;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rs = 1'b0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] id_dst = '0;
  logic       id_regwrite = 1'b0;
  logic       id_load = 1'b0;
  logic       id_muldiv = 1'b0;
  logic       flush = 1'b0;
  logic       stall_if_id;
  logic       bubble_ex;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

`ifdef HAZ_MULDIV_EN
  hazard_fwd_unit #(.REG_AW(5), .MULDIV_CYCLES(4)) dut (
`else
  hazard_fwd_unit #(.REG_AW(5)) dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_dst      (id_dst),
    .id_regwrite (id_regwrite),
    .id_load     (id_load),
`ifdef HAZ_MULDIV_EN
    .id_muldiv   (id_muldiv),
`endif
    .flush       (flush),
    .stall_if_id (stall_if_id),
    .bubble_ex   (bubble_ex),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  // ---------------- model ----------------
  ins_t hist [0:1023];
  int   cyc    = 0;
  int   rst_at = 0;
  int   mstart = -100000;

  function automatic ins_t get(input int i);
    ins_t r;
    r = '0;
    if (i > rst_at) r = hist[i & 1023];
    return r;
  endfunction

  function automatic bit exp_ldhz();
    ins_t e;
    e = get(cyc);
    return id_valid && e.v && e.ld && e.rw && (e.dst != 0) &&
           ((id_uses_rs && id_rs == e.dst) || (id_uses_rt && id_rt == e.dst));
  endfunction

  function automatic bit exp_busy();
    return (MC > 0) && (cyc >= mstart) && ((cyc - mstart) < MC - 1);
  endfunction

  function automatic bit exp_stall();
    return !rst && !flush && (exp_ldhz() || exp_busy());
  endfunction

  function automatic bit exp_bubble();
    return !rst && (exp_ldhz() || exp_busy() || flush);
  endfunction

  function automatic logic [1:0] exp_fwd(input bit side_b);
    ins_t e, m, w;
    bit       u;
    bit [4:0] s;
    e = get(cyc);
    m = get(cyc - 1);
    w = get(cyc - 2);
    u = side_b ? e.urt : e.urs;
    s = side_b ? e.rt  : e.rs;
    if (rst || !e.v || !u) return 2'b00;
    if (m.v && m.rw && !m.ld && m.dst != 0 && m.dst == s) return 2'b10;
    if (w.v && w.rw && w.dst != 0 && w.dst == s) return 2'b01;
    return 2'b00;
  endfunction

  function automatic ins_t mk_cap();
    ins_t r;
    r.v   = id_valid && !exp_stall() && !flush;
    r.rs  = id_rs;
    r.rt  = id_rt;
    r.dst = id_dst;
    r.urs = id_uses_rs;
    r.urt = id_uses_rt;
    r.rw  = id_regwrite;
    r.ld  = id_load;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rst_at <= cyc + 1;
      mstart <= -100000;
    end else begin
      hist[(cyc + 1) & 1023] <= mk_cap();
      if (id_valid && id_muldiv && !exp_stall() && !flush && MC > 0)
        mstart <= cyc + 1;
    end
    cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model stall_if_id", 32'(stall_if_id), 32'(exp_stall()));
    check("model bubble_ex",   32'(bubble_ex),   32'(exp_bubble()));
    check("model fwd_a",       32'(fwd_a),       32'(exp_fwd(1'b0)));
    check("model fwd_b",       32'(fwd_b),       32'(exp_fwd(1'b1)));
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic ins(input bit v, input int rs, input int rt, input int dst,
                     input bit urs, input bit urt, input bit rw, input bit ld,
                     input bit md = 1'b0);
    id_valid    = v;
    id_rs       = 5'(rs);
    id_rt       = 5'(rt);
    id_dst      = 5'(dst);
    id_uses_rs  = urs;
    id_uses_rt  = urt;
    id_regwrite = rw;
    id_load     = ld;
    id_muldiv   = md;
  endtask

  task automatic nop();
    ins(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop();
    repeat (3) nxt();
  endtask

  task automatic lit4(input string tag, input logic s, input logic b,
                      input logic [1:0] fa, input logic [1:0] fb);
    check({tag, " stall"}, 32'(stall_if_id), 32'(s));
    check({tag, " bubble"}, 32'(bubble_ex), 32'(b));
    check({tag, " fwd_a"}, 32'(fwd_a), 32'(fa));
    check({tag, " fwd_b"}, 32'(fwd_b), 32'(fb));
  endtask

  ins_t tbl [0:7];
  int   stall_cnt;
  int   idx;

  initial begin
    // Reset with a would-be hazard presented: outputs must stay 0.
    ins(1, 3, 3, 4, 1, 1, 1, 1);
    nxt();
    nxt();
    mid();
    lit4("reset", 0, 0, 2'b00, 2'b00);
    nxt();
    rst = 1'b0;
    drain();
    mid();
    lit4("post-reset", 0, 0, 2'b00, 2'b00);

    // add $3,$1,$2 ; sub $4,$3,$5
    nxt();
    ins(1, 1, 2, 3, 1, 1, 1, 0);
    nxt();
    ins(1, 3, 5, 4, 1, 1, 1, 0);
    nxt();
    nop();
    mid();
    lit4("ex-mem fwd", 0, 0, 2'b10, 2'b00);

    // add $3 ; nop ; or $6,$5,$3
    drain();
    ins(1, 1, 2, 3, 1, 1, 1, 0);
    nxt();
    nop();
    nxt();
    ins(1, 5, 3, 6, 1, 1, 1, 0);
    nxt();
    nop();
    mid();
    lit4("wb fwd", 0, 0, 2'b00, 2'b01);

    // lw $3 ; add $4,$3,$3
    drain();
    ins(1, 1, 0, 3, 1, 0, 1, 1);
    nxt();
    ins(1, 3, 3, 4, 1, 1, 1, 0);
    mid();
    lit4("load-use", 1, 1, 2'b00, 2'b00);
    nxt();
    mid();
    check("load-use released", 32'(stall_if_id), 32'd0);
    nxt();
    nop();
    mid();
    lit4("load fwd", 0, 0, 2'b01, 2'b01);

    // add $0,$1,$2 ; add $4,$0,$0
    drain();
    ins(1, 1, 2, 0, 1, 1, 1, 0);
    nxt();
    ins(1, 0, 0, 4, 1, 1, 1, 0);
    nxt();
    nop();
    mid();
    lit4("r0 no fwd", 0, 0, 2'b00, 2'b00);

    // add $3 ; add $3 ; add $5,$3,$3
    drain();
    ins(1, 1, 2, 3, 1, 1, 1, 0);
    nxt();
    ins(1, 4, 2, 3, 1, 1, 1, 0);
    nxt();
    ins(1, 3, 3, 5, 1, 1, 1, 0);
    nxt();
    nop();
    mid();
    lit4("mem priority", 0, 0, 2'b10, 2'b10);

    // Reset in the middle of a load-use stall.
    drain();
    ins(1, 1, 0, 3, 1, 0, 1, 1);
    nxt();
    ins(1, 3, 3, 4, 1, 1, 1, 0);
    rst = 1'b1;
    mid();
    lit4("rst in stall", 0, 0, 2'b00, 2'b00);
    nxt();
    rst = 1'b0;
    mid();
    lit4("after rst", 0, 0, 2'b00, 2'b00);

    // Flush coinciding with a load-use hazard.
    drain();
    ins(1, 1, 0, 3, 1, 0, 1, 1);
    nxt();
    ins(1, 3, 3, 4, 1, 1, 1, 0);
    flush = 1'b1;
    mid();
    lit4("flush+ldhz", 0, 1, 2'b00, 2'b00);
    nxt();
    flush = 1'b0;
    nop();
    mid();
    lit4("after flush", 0, 0, 2'b00, 2'b00);

    // mult enters EX, followed by an independent instruction held in ID.
    drain();
    ins(1, 1, 2, 0, 1, 1, 0, 0, 1'b1);
    nxt();
    ins(1, 7, 8, 9, 1, 1, 1, 0);
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (stall_if_id === 1'b1) stall_cnt++;
      nxt();
    end
    check("muldiv stall cycles", 32'(stall_cnt), (MC > 0) ? 32'd3 : 32'd0);

    // Back-to-back mix; the ID instruction is held while the DUT stalls.
    drain();
    tbl[0] = '{1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1};  // lw  $2
    tbl[1] = '{1'b1, 5'd2, 5'd1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0};  // add $3,$2,$1
    tbl[2] = '{1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1};  // lw  $4,($3)
    tbl[3] = '{1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0};  // sub $5,$4,$3
    tbl[4] = '{1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0};  // add $0
    tbl[5] = '{1'b1, 5'd0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0};  // or  $6,$0,$5
    tbl[6] = '{1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1};  // lw  $7,($6)
    tbl[7] = '{1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0};  // and $8,$7,$7
    idx = 0;
    for (int it = 0; it < 40 && idx < 8; it++) begin
      ins(tbl[idx].v, tbl[idx].rs, tbl[idx].rt, tbl[idx].dst,
          tbl[idx].urs, tbl[idx].urt, tbl[idx].rw, tbl[idx].ld);
      mid();
      if (stall_if_id !== 1'b1) idx++;
      nxt();
    end
    check("mix sequence completed", 32'(idx), 32'd8);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
